// File: rtl/spi_segment_scan_controller_if.sv
// SPI pins plus the display outputs of the segment scan controller.
// The slave modport belongs to the controller; the master modport drives the SPI side.
interface spi_segment_scan_controller_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                  spi_sclk;
  logic                  spi_mosi;
  logic                  spi_cs_n;
  logic [7:0]            seg;
  logic [NUM_DIGITS-1:0] dig_sel;
  logic                  frame_ok;
  logic                  frame_err;

  modport master (
    output spi_sclk, spi_mosi, spi_cs_n,
    input  seg, dig_sel, frame_ok, frame_err
  );

  modport slave (
    input  spi_sclk, spi_mosi, spi_cs_n,
    output seg, dig_sel, frame_ok, frame_err
  );
endinterface

// File: rtl/spi_segment_scan_controller.sv
// SPI-slave-written, time-multiplexed 7-segment controller: a 16-bit frame receiver
// feeding per-digit raw/hex registers, plus a one-hot digit scanner with blank and blink.
module spi_segment_scan_controller #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter logic [23:0] SCAN_DIV   = 24'd10_000,
  parameter logic [7:0]  BLINK_DIV  = 8'd200
) (
  input logic                          clk,
  input logic                          rst,
  spi_segment_scan_controller_if.slave bus
);
  localparam int unsigned ADDR_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned SEG_W   = 8;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(16);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(17);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_t;

  typedef struct packed {
    logic [3:0] cmd;
    logic [3:0] addr;
    logic [7:0] data;
  } frame_t;

  // Synchronisers: [1] is the synchronised value, [2] its previous value for edge detect.
  // Left unreset so a cs_n held low across reset does not look like a fresh falling edge.
  logic [2:0] sclk_sync;
  logic [2:0] cs_sync;
  logic [1:0] mosi_sync;

  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[1:0], bus.spi_sclk};
    cs_sync   <= {cs_sync[1:0], bus.spi_cs_n};
    mosi_sync <= {mosi_sync[0], bus.spi_mosi};
  end

  logic sclk_rise_c, cs_fall_c, cs_rise_c;
  assign sclk_rise_c = sclk_sync[1] & ~sclk_sync[2];
  assign cs_fall_c   = ~cs_sync[1] & cs_sync[2];
  assign cs_rise_c   = cs_sync[1] & ~cs_sync[2];

  state_t               state_q, state_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 commit_ok_c, commit_err_c;
  logic [SEG_W-1:0]     digit_q [NUM_DIGITS];
  logic                 hex_q   [NUM_DIGITS];
  logic [1:0]           ctrl_q;
  logic                 frame_ok_q, frame_err_q;

  frame_t               frame_c;
  logic [ADDR_W-1:0]    addr_idx_c;
  logic                 addr_ok_c, frame_valid_c;

  assign frame_c    = frame_t'(shift_q);
  assign addr_idx_c = frame_c.addr[ADDR_W-1:0];
  assign addr_ok_c  = 32'(frame_c.addr) < NUM_DIGITS;

  // A frame is accepted only with exactly 16 bits and a known, in-range command.
  always_comb begin
    frame_valid_c = 1'b0;
    if (bit_cnt_q == CNT_FULL) begin
      case (frame_c.cmd)
        4'h1, 4'h2: frame_valid_c = addr_ok_c;
        4'h3, 4'h4: frame_valid_c = 1'b1;
        default:    frame_valid_c = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Receiver next state; the commit decision is taken on the SHIFT->COMMIT transition.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    commit_ok_c  = 1'b0;
    commit_err_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall_c) begin
          state_d   = ST_SHIFT;
          shift_d   = '0;
          bit_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (cs_rise_c) begin
          state_d      = ST_COMMIT;
          commit_ok_c  = frame_valid_c;
          commit_err_c = ~frame_valid_c;
        end else if (sclk_rise_c) begin
          shift_d = {shift_q[FRAME_W-2:0], mosi_sync[1]};
          if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_q[i] <= '0;
        hex_q[i]   <= 1'b0;
      end
      ctrl_q      <= 2'b01;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_ok_q  <= commit_ok_c;
      frame_err_q <= commit_err_c;
      if (commit_ok_c) begin
        case (frame_c.cmd)
          4'h1: begin
            digit_q[addr_idx_c] <= frame_c.data;
            hex_q[addr_idx_c]   <= 1'b0;
          end
          4'h2: begin
            digit_q[addr_idx_c] <= {frame_c.data[7], 3'b000, frame_c.data[3:0]};
            hex_q[addr_idx_c]   <= 1'b1;
          end
          4'h3: ctrl_q <= frame_c.data[1:0];
          4'h4: begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
              digit_q[i] <= '0;
              hex_q[i]   <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic [23:0]       div_cnt_q;
  logic [ADDR_W-1:0] scan_idx_q;
  logic [7:0]        blink_cnt_q;
  logic              blink_phase_q;

  // Scan timing: digit advances every SCAN_DIV clk, blink phase every BLINK_DIV full frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q     <= '0;
      scan_idx_q    <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (div_cnt_q == SCAN_DIV - 24'd1) begin
      div_cnt_q <= '0;
      if (scan_idx_q == LAST_IDX) begin
        scan_idx_q <= '0;
        if (blink_cnt_q == BLINK_DIV - 8'd1) begin
          blink_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 8'd1;
        end
      end else begin
        scan_idx_q <= scan_idx_q + ADDR_W'(1);
      end
    end else begin
      div_cnt_q <= div_cnt_q + 24'd1;
    end
  end

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  logic [SEG_W-1:0] cur_digit_c, seg_c;
  logic             blank_c;

  always_comb begin
    cur_digit_c = digit_q[scan_idx_q];
    blank_c     = ~ctrl_q[0] | (ctrl_q[1] & blink_phase_q);
    seg_c       = hex_q[scan_idx_q] ? {cur_digit_c[7], hex_to_seg(cur_digit_c[3:0])}
                                    : cur_digit_c;
    if (blank_c) seg_c = '0;
  end

  logic [SEG_W-1:0]      seg_q;
  logic [NUM_DIGITS-1:0] dig_sel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q     <= '0;
      dig_sel_q <= NUM_DIGITS'(1);
    end else begin
      seg_q     <= seg_c;
      dig_sel_q <= NUM_DIGITS'(1) << scan_idx_q;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.dig_sel   = dig_sel_q;
  assign bus.frame_ok  = frame_ok_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_segment_scan_controller.sv
// Directed bench for spi_segment_scan_controller: SPI frames in, pulses and scanned segments out.
module tb_spi_segment_scan_controller;
  localparam int unsigned ND = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  spi_segment_scan_controller_if #(.NUM_DIGITS(ND)) bus ();

  spi_segment_scan_controller #(
    .NUM_DIGITS(ND),
    .SCAN_DIV  (24'd4),
    .BLINK_DIV (8'd2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Waits (bounded) for dig_sel to newly become want; returns at a negedge.
  task automatic wait_sel(input logic [ND-1:0] want, output bit ok);
    int n = 0;
    @(negedge clk);
    while (bus.dig_sel == want && n < 100) begin @(negedge clk); n++; end
    while (bus.dig_sel != want && n < 100) begin @(negedge clk); n++; end
    ok = (bus.dig_sel == want);
  endtask

  task automatic spi_bit(input logic b);
    bus.spi_mosi = b;
    repeat (2) @(negedge clk);
    bus.spi_sclk = 1'b1;
    repeat (2) @(negedge clk);
    bus.spi_sclk = 1'b0;
  endtask

  // Sends the low n bits MSB first and counts result pulses after cs_n rises.
  task automatic spi_send(input logic [31:0] bits, input int n, output int oks, output int errs);
    bus.spi_cs_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) spi_bit(bits[i]);
    repeat (2) @(negedge clk);
    bus.spi_cs_n = 1'b1;
    oks = 0;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      oks  += int'(bus.frame_ok);
      errs += int'(bus.frame_err);
    end
    bus.spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.spi_cs_n = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    tests++;
    if (bus.seg !== 8'h00 || bus.dig_sel !== 4'b0001 || bus.frame_ok !== 1'b0 || bus.frame_err !== 1'b0) begin
      fails++;
      $display("FAIL reset: seg=%h dig_sel=%b ok=%b err=%b, want 00 0001 0 0",
               bus.seg, bus.dig_sel, bus.frame_ok, bus.frame_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    bit ok;
    logic [ND-1:0] exp;
    wait_sel(4'b0010, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL scan_start: dig_sel=%b never reached 0010", bus.dig_sel); end
    for (int i = 0; i < 16; i++) begin
      case ((i / 4 + 1) % 4)
        0: exp = 4'b0001;
        1: exp = 4'b0010;
        2: exp = 4'b0100;
        default: exp = 4'b1000;
      endcase
      tests++;
      if (bus.dig_sel !== exp || bus.seg !== 8'h00) begin
        fails++;
        $display("FAIL scan_cycle %0d: dig_sel=%b seg=%h, want %b 00", i, bus.dig_sel, bus.seg, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_hex();
    int oks, errs;
    bit ok;
    spi_send(32'h218A, 16, oks, errs);
    tests++;
    if (oks != 1 || errs != 0) begin
      fails++;
      $display("FAIL hex_frame: ok pulses=%0d err pulses=%0d, want 1 0", oks, errs);
    end
    wait_sel(4'b0010, ok);
    tests++;
    if (!ok || bus.seg !== 8'hF7) begin
      fails++;
      $display("FAIL hex_digit1: seg=%h, want F7", bus.seg);
    end
    wait_sel(4'b0001, ok);
    tests++;
    if (!ok || bus.seg !== 8'h00) begin
      fails++;
      $display("FAIL hex_digit0: seg=%h, want 00", bus.seg);
    end
  endtask

  task automatic test_raw_disable();
    int oks, errs;
    bit ok;
    spi_send(32'h1355, 16, oks, errs);
    tests++;
    if (oks != 1 || errs != 0) begin
      fails++;
      $display("FAIL raw_frame: ok pulses=%0d err pulses=%0d, want 1 0", oks, errs);
    end
    wait_sel(4'b1000, ok);
    tests++;
    if (!ok || bus.seg !== 8'h55) begin
      fails++;
      $display("FAIL raw_digit3: seg=%h, want 55", bus.seg);
    end
    spi_send(32'h3000, 16, oks, errs);
    tests++;
    if (oks != 1 || errs != 0) begin
      fails++;
      $display("FAIL disable_frame: ok pulses=%0d err pulses=%0d, want 1 0", oks, errs);
    end
    for (int d = 0; d < 4; d++) begin
      logic [ND-1:0] sel;
      sel = 4'b0001 << d;
      wait_sel(sel, ok);
      tests++;
      if (!ok || bus.seg !== 8'h00) begin
        fails++;
        $display("FAIL disabled_digit%0d: ok=%0d seg=%h, want 1 00", d, ok, bus.seg);
      end
    end
    spi_send(32'h3001, 16, oks, errs);
    tests++;
    if (oks != 1 || errs != 0) begin
      fails++;
      $display("FAIL enable_frame: ok pulses=%0d err pulses=%0d, want 1 0", oks, errs);
    end
  endtask

  task automatic test_errors();
    int oks, errs;
    bit ok;
    logic [31:0] frames [5] = '{32'h10FF, 32'h010FF, 32'h14FF, 32'hF0FF, 32'h0};
    int          lens   [5] = '{15, 17, 16, 16, 0};
    for (int f = 0; f < 5; f++) begin
      spi_send(frames[f], lens[f], oks, errs);
      tests++;
      if (oks != 0 || errs != 1) begin
        fails++;
        $display("FAIL err_frame%0d: ok pulses=%0d err pulses=%0d, want 0 1", f, oks, errs);
      end
    end
    wait_sel(4'b0001, ok);
    tests++;
    if (!ok || bus.seg !== 8'h00) begin fails++; $display("FAIL err_digit0: seg=%h, want 00", bus.seg); end
    wait_sel(4'b0010, ok);
    tests++;
    if (!ok || bus.seg !== 8'hF7) begin fails++; $display("FAIL err_digit1: seg=%h, want F7", bus.seg); end
    wait_sel(4'b1000, ok);
    tests++;
    if (!ok || bus.seg !== 8'h55) begin fails++; $display("FAIL err_digit3: seg=%h, want 55", bus.seg); end
  endtask

  task automatic test_clear();
    int oks, errs;
    bit ok;
    spi_send(32'h4000, 16, oks, errs);
    tests++;
    if (oks != 1 || errs != 0) begin
      fails++;
      $display("FAIL clear_frame: ok pulses=%0d err pulses=%0d, want 1 0", oks, errs);
    end
    wait_sel(4'b0010, ok);
    tests++;
    if (!ok || bus.seg !== 8'h00) begin fails++; $display("FAIL clear_digit1: seg=%h, want 00", bus.seg); end
    wait_sel(4'b1000, ok);
    tests++;
    if (!ok || bus.seg !== 8'h00) begin fails++; $display("FAIL clear_digit3: seg=%h, want 00", bus.seg); end
  endtask

  task automatic test_blink();
    int oks, errs, k;
    bit ok;
    logic [7:0] v [11];
    logic [7:0] exp;
    spi_send(32'h2008, 16, oks, errs);
    wait_sel(4'b0001, ok);
    tests++;
    if (oks != 1 || !ok || bus.seg !== 8'h7F) begin
      fails++;
      $display("FAIL blink_setup: ok pulses=%0d seg=%h, want 1 7F", oks, bus.seg);
    end
    spi_send(32'h3003, 16, oks, errs);
    tests++;
    if (oks != 1 || errs != 0) begin
      fails++;
      $display("FAIL blink_frame: ok pulses=%0d err pulses=%0d, want 1 0", oks, errs);
    end
    for (int f = 0; f < 11; f++) begin
      wait_sel(4'b0001, ok);
      v[f] = ok ? bus.seg : 8'hXX;
    end
    k = 0;
    for (int f = 2; f >= 1; f--) if (v[f] !== v[f-1]) k = f;
    tests++;
    if (k == 0 || (v[k] !== 8'h7F && v[k] !== 8'h00)) begin
      fails++;
      $display("FAIL blink_edge: first samples %h %h %h, want a 7F/00 change within two frames",
               v[0], v[1], v[2]);
    end else begin
      for (int j = k; j < k + 8; j++) begin
        exp = (((j - k) / 2) % 2 == 0) ? v[k] : (v[k] ^ 8'h7F);
        tests++;
        if (v[j] !== exp) begin
          fails++;
          $display("FAIL blink_frame%0d: seg=%h, want %h", j, v[j], exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int oks, errs;
    bit ok;
    logic [7:0] part = 8'h21;
    oks = 0;
    errs = 0;
    bus.spi_cs_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 7; i >= 0; i--) spi_bit(part[i]);
    rst = 1'b1;
    repeat (4) begin @(negedge clk); oks += int'(bus.frame_ok); errs += int'(bus.frame_err); end
    rst = 1'b0;
    repeat (4) begin @(negedge clk); oks += int'(bus.frame_ok); errs += int'(bus.frame_err); end
    bus.spi_cs_n = 1'b1;
    repeat (10) begin @(negedge clk); oks += int'(bus.frame_ok); errs += int'(bus.frame_err); end
    tests++;
    if (oks != 0 || errs != 0) begin
      fails++;
      $display("FAIL reset_mid_pulses: ok pulses=%0d err pulses=%0d, want 0 0", oks, errs);
    end
    spi_send(32'h2008, 16, oks, errs);
    tests++;
    if (oks != 1 || errs != 0) begin
      fails++;
      $display("FAIL reset_mid_frame: ok pulses=%0d err pulses=%0d, want 1 0", oks, errs);
    end
    wait_sel(4'b0001, ok);
    tests++;
    if (!ok || bus.seg !== 8'h7F) begin fails++; $display("FAIL reset_mid_digit0: seg=%h, want 7F", bus.seg); end
    wait_sel(4'b1000, ok);
    tests++;
    if (!ok || bus.seg !== 8'h00) begin fails++; $display("FAIL reset_mid_digit3: seg=%h, want 00", bus.seg); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_hex();
    test_raw_disable();
    test_errors();
    test_clear();
    test_blink();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
